// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline stages and the enable/clear vector sent back to them.
// Latency: none, this file holds only wires.
// Backpressure: the controller stalls stages via en_*; the pipeline has no way to refuse it.
interface pipeline_ctrl_if;
  // hazard sources, driven by the pipeline
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ex_load;
  logic [4:0]  ex_rt;
  logic        id_branch_taken;
  logic        ex_mdu_start;
  logic        mem_busy;
  logic        mem_exc;
  // register controls, driven by the controller
  logic        en_pc;
  logic        en_ifid;
  logic        en_idex;
  logic        en_exmem;
  logic        en_memwb;
  logic        clr_ifid;
  logic        clr_idex;
  logic        clr_exmem;
  logic        clr_memwb;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_load, ex_rt,
           id_branch_taken, ex_mdu_start, mem_busy, mem_exc,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           clr_ifid, clr_idex, clr_exmem, clr_memwb,
           mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_load, ex_rt,
           id_branch_taken, ex_mdu_start, mem_busy, mem_exc,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           clr_ifid, clr_idex, clr_exmem, clr_memwb,
           mdu_busy, mdu_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline plus a saturating stall-cycle counter.
// Latency: enables/clears are combinational from inputs (zero cycles); stall_cycles is registered.
// Backpressure: mem_busy freezes PC..EX/MEM, an MDU op freezes PC..ID/EX for MDU_CYCLES cycles.
module pipeline_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter bit DELAY_SLOT = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  pipeline_ctrl_if.slave ctrl
);

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MDU_CYCLES - 2);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] stall_q;

  logic load_use;
  logic mdu_act;
  logic mdu_fin;

  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic clr_ifid, clr_idex, clr_exmem, clr_memwb;
  logic mdu_busy, mdu_done;

  // A load in EX writing a register the ID instruction reads; r0 never hazards.
  assign load_use = ctrl.ex_load && (ctrl.ex_rt != 5'd0) &&
                    ((ctrl.id_use_rs && (ctrl.ex_rt == ctrl.id_rs)) ||
                     (ctrl.id_use_rt && (ctrl.ex_rt == ctrl.id_rt)));

  // An op is active from the first cycle start is seen; it finishes once the countdown is spent.
  assign mdu_act = (state_q == MDU) || ctrl.ex_mdu_start;
  assign mdu_fin = (state_q == MDU) && (cnt_q == 8'd0);

  // State and MDU countdown registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the countdown keeps running under mem_busy, but completion waits for it to drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ctrl.mem_exc) begin
      state_d = RUN;
      cnt_d   = 8'd0;
    end else if (state_q == RUN) begin
      if (ctrl.ex_mdu_start) begin
        state_d = MDU;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else if (!ctrl.mem_busy) begin
        state_d = RUN;
      end
    end
  end

  // Outputs: only the highest-priority active condition drives the register controls.
  always_comb begin
    en_pc     = 1'b1;
    en_ifid   = 1'b1;
    en_idex   = 1'b1;
    en_exmem  = 1'b1;
    en_memwb  = 1'b1;
    clr_ifid  = 1'b0;
    clr_idex  = 1'b0;
    clr_exmem = 1'b0;
    clr_memwb = 1'b0;
    mdu_busy  = 1'b0;
    mdu_done  = 1'b0;
    if (!rst_n) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      en_memwb  = 1'b0;
      clr_ifid  = 1'b1;
      clr_idex  = 1'b1;
      clr_exmem = 1'b1;
      clr_memwb = 1'b1;
    end else if (ctrl.mem_exc) begin
      clr_ifid  = 1'b1;
      clr_idex  = 1'b1;
      clr_exmem = 1'b1;
      clr_memwb = 1'b1;
    end else if (ctrl.mem_busy) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      clr_memwb = 1'b1;
    end else if (mdu_act) begin
      if (mdu_fin) begin
        mdu_done = 1'b1;
      end else begin
        en_pc     = 1'b0;
        en_ifid   = 1'b0;
        en_idex   = 1'b0;
        clr_exmem = 1'b1;
        mdu_busy  = 1'b1;
      end
    end else if (load_use) begin
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      clr_idex = 1'b1;
    end else if (ctrl.id_branch_taken && !DELAY_SLOT) begin
      clr_ifid = 1'b1;
    end
  end

  // Performance counter: cycles with the PC frozen, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else if (!en_pc && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign ctrl.en_pc        = en_pc;
  assign ctrl.en_ifid      = en_ifid;
  assign ctrl.en_idex      = en_idex;
  assign ctrl.en_exmem     = en_exmem;
  assign ctrl.en_memwb     = en_memwb;
  assign ctrl.clr_ifid     = clr_ifid;
  assign ctrl.clr_idex     = clr_idex;
  assign ctrl.clr_exmem    = clr_exmem;
  assign ctrl.clr_memwb    = clr_memwb;
  assign ctrl.mdu_busy     = mdu_busy;
  assign ctrl.mdu_done     = mdu_done;
  assign ctrl.stall_cycles = stall_q;

endmodule
